mod12_counter: RTL and testbench

MOD12_COUNTER -- requirements
Module: mod12_counter

---
 rtl/mod12_counter.sv | 46 ++++
 tb/tb_mod12_counter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mod12_counter.sv
// Modulo-12 up/down counter with parallel load; optional terminal-count flag tc under `MOD12_TC_EN`.
// One clk from sampled load/count to dataout; no backpressure, the counter steps every cycle unless reset or loaded.
module mod12_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] datain,
  input  logic       load,
  input  logic       mode,
`ifdef MOD12_TC_EN
  output logic       tc,
`endif
  output logic [3:0] dataout
);

  localparam logic [3:0] MAX_VAL = 4'd11;

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Values above MAX_VAL can only come from an unreset register; steer them back into range.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = (datain > MAX_VAL) ? 4'd0 : datain;
    end else if (mode) begin
      count_d = (count_q >= MAX_VAL) ? 4'd0 : count_q + 4'd1;
    end else begin
      count_d = ((count_q == 4'd0) || (count_q > MAX_VAL)) ? MAX_VAL : count_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign dataout = count_q;

`ifdef MOD12_TC_EN
  assign tc = (mode && (count_q == MAX_VAL)) || (!mode && (count_q == 4'd0));
`endif

endmodule

// File: tb/tb_mod12_counter.sv
// Directed and random checks of mod12_counter: reset, load clamping, up/down wrap, reset priority.
// Outputs are sampled 1 time unit after each rising edge.
module tb_mod12_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] datain = 4'd0;
  logic       load = 1'b0;
  logic       mode = 1'b1;
  logic [3:0] dataout;
`ifdef MOD12_TC_EN
  logic       tc;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mod12_counter dut (
    .clk     (clk),
    .rst     (rst),
    .datain  (datain),
    .load    (load),
    .mode    (mode),
`ifdef MOD12_TC_EN
    .tc      (tc),
`endif
    .dataout (dataout)
  );

  always #5 clk = ~clk;

  task automatic apply(input logic r, input logic l, input logic m, input logic [3:0] d);
    rst    = r;
    load   = l;
    mode   = m;
    datain = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] exp);
    n_tests++;
    assert (dataout === exp)
    else begin
      n_fail++;
      $error("FAIL %s dataout observed=%0d expected=%0d", tag, dataout, exp);
    end
  endtask

  task automatic check_tc(input string tag, input logic exp);
`ifdef MOD12_TC_EN
    n_tests++;
    assert (tc === exp)
    else begin
      n_fail++;
      $error("FAIL %s tc observed=%0b expected=%0b", tag, tc, exp);
    end
`endif
  endtask

  function automatic logic [3:0] model_next(input logic [3:0] cur, input logic r,
                                            input logic l, input logic m, input logic [3:0] d);
    if (!r)       return 4'd0;
    else if (l)   return (d > 4'd11) ? 4'd0 : d;
    else if (m)   return (cur == 4'd11) ? 4'd0 : cur + 4'd1;
    else          return (cur == 4'd0) ? 4'd11 : cur - 4'd1;
  endfunction

  initial begin
    logic [3:0] exp_q;
    logic       r_r, r_l, r_m;
    logic [3:0] r_d;

    // Reset overrides a pending load.
    apply(1'b0, 1'b1, 1'b1, 4'd7);  check_out("rst_1", 4'd0);
    apply(1'b0, 1'b1, 1'b1, 4'd7);  check_out("rst_2", 4'd0);
    check_tc("tc_rst_up", 1'b0);

    // Load 9 then count up across the wrap.
    apply(1'b1, 1'b1, 1'b1, 4'd9);  check_out("load9", 4'd9);
    apply(1'b1, 1'b0, 1'b1, 4'd0);  check_out("up_10", 4'd10);
    apply(1'b1, 1'b0, 1'b1, 4'd0);  check_out("up_11", 4'd11);
    check_tc("tc_up_11", 1'b1);
    apply(1'b1, 1'b0, 1'b1, 4'd0);  check_out("up_wrap0", 4'd0);
    check_tc("tc_up_0", 1'b0);
    apply(1'b1, 1'b0, 1'b1, 4'd0);  check_out("up_1", 4'd1);

    // Load 1 then count down across the wrap.
    apply(1'b1, 1'b1, 1'b0, 4'd1);  check_out("load1", 4'd1);
    check_tc("tc_dn_1", 1'b0);
    apply(1'b1, 1'b0, 1'b0, 4'd0);  check_out("dn_0", 4'd0);
    check_tc("tc_dn_0", 1'b1);
    apply(1'b1, 1'b0, 1'b0, 4'd0);  check_out("dn_wrap11", 4'd11);
    check_tc("tc_dn_11", 1'b0);
    apply(1'b1, 1'b0, 1'b0, 4'd0);  check_out("dn_10", 4'd10);
    check_tc("tc_dn_10", 1'b0);

    // Out-of-range loads clamp to 0; max in-range load is kept.
    apply(1'b1, 1'b1, 1'b1, 4'd14); check_out("load14", 4'd0);
    apply(1'b1, 1'b1, 1'b0, 4'd11); check_out("load11", 4'd11);
    apply(1'b1, 1'b1, 1'b1, 4'd15); check_out("load15", 4'd0);
    apply(1'b1, 1'b1, 1'b0, 4'd3);  check_out("load3", 4'd3);
    apply(1'b1, 1'b1, 1'b1, 4'd12); check_out("load12", 4'd0);

    // Mode flip takes effect on the first edge.
    apply(1'b1, 1'b1, 1'b1, 4'd6);  check_out("load6", 4'd6);
    apply(1'b1, 1'b0, 1'b0, 4'd0);  check_out("flip_dn5", 4'd5);
    apply(1'b1, 1'b0, 1'b1, 4'd0);  check_out("flip_up6", 4'd6);

    // Reset mid-count beats load, then counting resumes from 0.
    apply(1'b1, 1'b1, 1'b1, 4'd5);  check_out("load5", 4'd5);
    apply(1'b0, 1'b1, 1'b1, 4'd9);  check_out("rst_mid", 4'd0);
    apply(1'b1, 1'b0, 1'b1, 4'd0);  check_out("resume_1", 4'd1);
    apply(1'b1, 1'b0, 1'b1, 4'd0);  check_out("resume_2", 4'd2);

    // Random transactions against the reference model.
    exp_q = 4'd2;
    for (int i = 0; i < 50; i++) begin
      r_r = ($urandom_range(0, 7) != 0);
      r_l = ($urandom_range(0, 3) == 0);
      r_m = 1'($urandom_range(0, 1));
      r_d = 4'($urandom_range(0, 15));
      exp_q = model_next(exp_q, r_r, r_l, r_m, r_d);
      apply(r_r, r_l, r_m, r_d);
      check_out("rand", exp_q);
      check_tc("rand_tc", (r_m && exp_q == 4'd11) || (!r_m && exp_q == 4'd0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
